// File: rtl/tag_flush_ctrl.sv
// Cache clean/flush engine: walks every tag line, requests writebacks for dirty lines
// and rewrites processed tags. Optional abort input enabled by `define TAG_FLUSH_ABORT_EN.
module tag_flush_ctrl #(
    parameter int NL  = 512,
    parameter int LSS = 9,
    parameter int LSH = LSS + 4,
    parameter int PSL = LSH + 1,
    parameter int TS  = 2 + (32 - PSL)
) (
    input  logic           nGCLK,
    input  logic           nRESET,
    input  logic           flush_req,
    input  logic           clean_only,
`ifdef TAG_FLUSH_ABORT_EN
    input  logic           flush_abort,
`endif
    output logic           flush_busy,
    output logic           flush_done,
    output logic [LSS-1:0] tag_read_sel,
    input  logic [TS-1:0]  tag_read_port,
    output logic [LSS-1:0] tag_write_sel,
    output logic [TS-1:0]  tag_write_port,
    output logic           tag_wr_ena,
    output logic           wb_req,
    output logic [31:0]    wb_addr,
    input  logic           wb_ack
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOOK = 3'd1,
        S_WB   = 3'd2,
        S_UPD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [LSS-1:0] index_q, index_d;
    logic [TS-1:0]  tag_q, tag_d;
    logic           clean_q, clean_d;
    logic           abort_now;
    logic           last_line;

    assign last_line = (index_q == LSS'(NL - 1));

`ifdef TAG_FLUSH_ABORT_EN
    // An abort seen during WB/UPD is remembered and acted on at the next LOOK.
    logic abort_q, abort_d;

    always_comb begin
        abort_d = abort_q;
        if (state_q == S_IDLE || state_q == S_DONE)
            abort_d = 1'b0;
        else if (flush_abort)
            abort_d = 1'b1;
    end

    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) abort_q <= 1'b0;
        else         abort_q <= abort_d;
    end

    assign abort_now = abort_q | flush_abort;
`else
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            index_q <= '0;
            tag_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            tag_q   <= tag_d;
            clean_q <= clean_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        tag_d   = tag_q;
        clean_d = clean_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    clean_d = clean_only;
                    index_d = '0;
                    state_d = S_LOOK;
                end
            end
            S_LOOK: begin
                if (abort_now) begin
                    state_d = S_DONE;
                end else begin
                    tag_d = tag_read_port;
                    if (tag_read_port[TS-2] && tag_read_port[TS-1])
                        state_d = S_WB;
                    else if (tag_read_port[TS-2] && !clean_q)
                        state_d = S_UPD;
                    else if (last_line)
                        state_d = S_DONE;
                    else
                        index_d = index_q + LSS'(1);
                end
            end
            S_WB: begin
                if (wb_ack) state_d = S_UPD;
            end
            S_UPD: begin
                if (last_line) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + LSS'(1);
                    state_d = S_LOOK;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        flush_busy     = (state_q == S_LOOK) || (state_q == S_WB) || (state_q == S_UPD);
        flush_done     = (state_q == S_DONE);
        wb_req         = (state_q == S_WB);
        wb_addr        = '0;
        tag_wr_ena     = (state_q == S_UPD);
        tag_write_sel  = '0;
        tag_write_port = '0;
        if (state_q == S_WB)
            wb_addr = {tag_q[TS-3:0], index_q, 5'b0};
        if (state_q == S_UPD) begin
            tag_write_sel = index_q;
            // Clean keeps the line valid; flush invalidates it entirely.
            if (clean_q)
                tag_write_port = {1'b0, 1'b1, tag_q[TS-3:0]};
        end
    end

    assign tag_read_sel = index_q;

endmodule

// File: tb/tb_tag_flush_ctrl.sv
// Scoreboard bench for tag_flush_ctrl: tag RAM model, delayed-ack bus model,
// and a monitor that checks every writeback handshake and tag write.
module tb_tag_flush_ctrl;

    localparam int NL = 512;
    localparam int LSS = 9;
    localparam int TS = 20;

    logic           nGCLK, nRESET;
    logic           flush_req, clean_only;
`ifdef TAG_FLUSH_ABORT_EN
    logic           flush_abort;
`endif
    logic           flush_busy, flush_done;
    logic [LSS-1:0] tag_read_sel, tag_write_sel;
    logic [TS-1:0]  tag_read_port, tag_write_port;
    logic           tag_wr_ena, wb_req, wb_ack;
    logic [31:0]    wb_addr;

    logic [TS-1:0]  ram [NL];
    logic [31:0]    exp_wb[$];
    logic [28:0]    exp_wr[$];
    int             checks, failures;
    int             wbreq_cyc, wr_cyc;
    int             ack_delay;

    tag_flush_ctrl dut (
        .nGCLK(nGCLK), .nRESET(nRESET),
        .flush_req(flush_req), .clean_only(clean_only),
`ifdef TAG_FLUSH_ABORT_EN
        .flush_abort(flush_abort),
`endif
        .flush_busy(flush_busy), .flush_done(flush_done),
        .tag_read_sel(tag_read_sel), .tag_read_port(tag_read_port),
        .tag_write_sel(tag_write_sel), .tag_write_port(tag_write_port),
        .tag_wr_ena(tag_wr_ena), .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack)
    );

    initial nGCLK = 1'b0;
    always #5 nGCLK = ~nGCLK;

    assign tag_read_port = ram[tag_read_sel];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Tag RAM write port: captured mid-cycle, committed at the edge that ends UPD.
    initial begin
        logic [LSS-1:0] ws;
        logic [TS-1:0]  wd;
        forever begin
            @(negedge nGCLK);
            if (nRESET && tag_wr_ena) begin
                ws = tag_write_sel;
                wd = tag_write_port;
                @(posedge nGCLK);
                if (nRESET) ram[ws] = wd;
            end
        end
    end

    // Bus unit: acks after ack_delay cycles of wb_req.
    initial begin
        int cnt;
        cnt = 0;
        wb_ack = 1'b0;
        forever begin
            @(posedge nGCLK);
            #1;
            if (wb_req && !wb_ack) begin
                if (cnt >= ack_delay) wb_ack = 1'b1;
                else cnt++;
            end else begin
                wb_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake / tag write.
    initial begin
        logic        prev_req;
        logic [31:0] prev_addr;
        prev_req = 1'b0;
        prev_addr = '0;
        wbreq_cyc = 0;
        wr_cyc = 0;
        forever begin
            @(negedge nGCLK);
            if (nRESET) begin
                if (wb_req) begin
                    wbreq_cyc++;
                    if (prev_req) chk("wb_addr_stable", wb_addr, prev_addr);
                end
                if (wb_req && wb_ack) begin
                    if (exp_wb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL wb_unexpected actual=%h expected=none", wb_addr);
                    end else chk("wb_addr", wb_addr, exp_wb.pop_front());
                end
                if (tag_wr_ena) begin
                    wr_cyc++;
                    if (exp_wr.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL wr_unexpected actual=%h expected=none", {tag_write_sel, tag_write_port});
                    end else chk("tag_write", {3'b0, tag_write_sel, tag_write_port}, {3'b0, exp_wr.pop_front()});
                end
                prev_req = wb_req;
                prev_addr = wb_addr;
            end
        end
    end

    task automatic start_walk(input logic clean);
        @(negedge nGCLK);
        flush_req = 1'b1;
        clean_only = clean;
        @(posedge nGCLK);
        #1;
        flush_req = 1'b0;
        clean_only = 1'b0;
    endtask

    task automatic wait_done(output int busy);
        logic seen;
        seen = 1'b0;
        busy = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge nGCLK);
            if (flush_done) begin
                seen = 1'b1;
                chk("busy_at_done", flush_busy, 0);
            end else if (flush_busy) busy++;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=no_done expected=flush_done");
        end
        @(negedge nGCLK);
        chk("done_pulse_width", flush_done, 0);
    endtask

    task automatic wait_wbreq();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge nGCLK);
            if (wb_req) seen = 1'b1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL wbreq_timeout actual=0 expected=1");
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < NL; i++) ram[i] = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, flush_busy, 0);
        chk({tag, "_done"}, flush_done, 0);
        chk({tag, "_wb_req"}, wb_req, 0);
        chk({tag, "_wb_addr"}, wb_addr, 0);
        chk({tag, "_wr_ena"}, tag_wr_ena, 0);
        chk({tag, "_rd_sel"}, 32'(tag_read_sel), 0);
        chk({tag, "_wr_sel_port"}, {3'b0, tag_write_sel, tag_write_port}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int busy, wb0, wr0;
        checks = 0;
        failures = 0;
        ack_delay = 0;
        nRESET = 1'b0;
        flush_req = 1'b0;
        clean_only = 1'b0;
`ifdef TAG_FLUSH_ABORT_EN
        flush_abort = 1'b0;
`endif
        clear_ram();

        // Reset state
        #23;
        check_outputs_zero("reset");
        @(negedge nGCLK);
        nRESET = 1'b1;

        // All-invalid walk: 512 busy cycles, no writes, no writebacks
        wr0 = wr_cyc; wb0 = wbreq_cyc;
        start_walk(1'b0);
        wait_done(busy);
        chk("invalid_busy_cycles", busy, 512);
        chk("invalid_writes", wr_cyc - wr0, 0);
        chk("invalid_wbreq", wbreq_cyc - wb0, 0);

        // Dirty line 5 with ack 3 cycles late; valid-clean line 9 flushed
        ram[5] = {2'b11, 18'h002A5};
        ram[9] = {2'b01, 18'h00033};
        ack_delay = 3;
        exp_wb.push_back(32'h00A940A0);
        exp_wr.push_back({9'd5, 20'h0});
        exp_wr.push_back({9'd9, 20'h0});
        wr0 = wr_cyc; wb0 = wbreq_cyc;
        start_walk(1'b0);
        wait_done(busy);
        chk("flush_busy_cycles", busy, 518);
        chk("flush_wbreq_cycles", wbreq_cyc - wb0, 4);
        chk("flush_writes", wr_cyc - wr0, 2);
        chk("flush_tag5", ram[5], 0);
        chk("flush_tag9", ram[9], 0);
        chk("flush_sb_empty", exp_wb.size() + exp_wr.size(), 0);

        // Clean: dirty line 7 written back and kept valid; clean line 8 untouched
        ram[7] = {2'b11, 18'h00010};
        ram[8] = {2'b01, 18'h00011};
        ack_delay = 1;
        exp_wb.push_back(32'h000400E0);
        exp_wr.push_back({9'd7, 2'b01, 18'h00010});
        wr0 = wr_cyc; wb0 = wbreq_cyc;
        start_walk(1'b1);
        wait_done(busy);
        chk("clean_busy_cycles", busy, 515);
        chk("clean_wbreq_cycles", wbreq_cyc - wb0, 2);
        chk("clean_writes", wr_cyc - wr0, 1);
        chk("clean_tag7", ram[7], {2'b01, 18'h00010});
        chk("clean_tag8", ram[8], {2'b01, 18'h00011});
        chk("clean_sb_empty", exp_wb.size() + exp_wr.size(), 0);

        // Asynchronous reset during the writeback of line 3
        clear_ram();
        ram[3]   = {2'b11, 18'h00123};
        ram[100] = {2'b11, 18'h00456};
        ack_delay = 50;
        start_walk(1'b0);
        wait_wbreq();
        chk("rst_walk_line", 32'(tag_read_sel), 3);
        #3;
        nRESET = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(negedge nGCLK);
        nRESET = 1'b1;
        chk("rst_tag3_kept", ram[3], {2'b11, 18'h00123});
        chk("rst_tag100_kept", ram[100], {2'b11, 18'h00456});
        ack_delay = 0;
        exp_wb.push_back({18'h00123, 9'd3, 5'b0});
        exp_wr.push_back({9'd3, 20'h0});
        exp_wb.push_back({18'h00456, 9'd100, 5'b0});
        exp_wr.push_back({9'd100, 20'h0});
        start_walk(1'b0);
        wait_done(busy);
        chk("restart_busy_cycles", busy, 516);
        chk("restart_tag3", ram[3], 0);
        chk("restart_tag100", ram[100], 0);
        chk("restart_sb_empty", exp_wb.size() + exp_wr.size(), 0);

`ifdef TAG_FLUSH_ABORT_EN
        // Abort during writeback of line 2: line 2 completes, line 3 untouched
        clear_ram();
        ram[2] = {2'b11, 18'h00AAA};
        ram[3] = {2'b11, 18'h00BBB};
        ack_delay = 2;
        exp_wb.push_back({18'h00AAA, 9'd2, 5'b0});
        exp_wr.push_back({9'd2, 20'h0});
        start_walk(1'b0);
        wait_wbreq();
        flush_abort = 1'b1;
        wait_done(busy);
        flush_abort = 1'b0;
        chk("abort_tag2", ram[2], 0);
        chk("abort_tag3_kept", ram[3], {2'b11, 18'h00BBB});
        chk("abort_sb_empty", exp_wb.size() + exp_wr.size(), 0);
`endif

        repeat (3) @(negedge nGCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
